// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NUM_REQ requesters.
// The winner's address drives the regfile in the grant cycle; its data and a one-hot valid come back a cycle later.
module regfile_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ADDR_WIDTH-1:0]            ctrl_readReg,
    input  logic [DATA_WIDTH-1:0]            data_readReg
);

    localparam int               PTR_W   = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   NREQ_W  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]    r_rsp_vld_p1;
    logic [DATA_WIDTH-1:0] r_rsp_data_p1;

    logic                  w_found;
    logic [PTR_W-1:0]      w_win;
    logic [PTR_W:0]        w_sum;
    logic                  w_gnt_vld_p0;

    // Stage p0: rotating search from r_ptr upward, wrapping modulo NUM_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PTR_W-1:0];
            end
        end
    end

    // Reset is asynchronous, so grants are masked while it is held.
    assign w_gnt_vld_p0 = en && !reset && w_found;

    always_comb begin
        grant        = '0;
        ctrl_readReg = '0;
        if (w_gnt_vld_p0) begin
            grant        = NUM_REQ'(1) << w_win;
            ctrl_readReg = req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Stage p1: capture regfile data for the winner and advance the pointer past it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr         <= '0;
            r_rsp_vld_p1  <= '0;
            r_rsp_data_p1 <= '0;
        end else if (w_gnt_vld_p0) begin
            r_ptr         <= (w_win == LAST_IX) ? '0 : w_win + 1'b1;
            r_rsp_vld_p1  <= grant;
            r_rsp_data_p1 <= data_readReg;
        end else begin
            r_rsp_vld_p1  <= '0;
        end
    end

    assign rsp_valid = r_rsp_vld_p1;
    assign rsp_data  = r_rsp_data_p1;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: NUM_REQ=4, 3-bit addresses, 8-bit data,
// with a small behavioural regfile answering ctrl_readReg combinationally.
module tb_regfile_read_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [3:0]  grant;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  ctrl_readReg;
    logic [7:0]  data_readReg;

    logic [7:0]  mem [8];

    int total = 0;
    int bad   = 0;

    logic [3:0] rot_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] rot_a [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [7:0] rot_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    regfile_read_arbiter #(
        .NUM_REQ    (4),
        .ADDR_WIDTH (3),
        .DATA_WIDTH (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .req          (req),
        .req_addr     (req_addr),
        .grant        (grant),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg)
    );

    assign data_readReg = mem[ctrl_readReg];

    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; req = 4'b1111; req_addr = 12'h000;
        @(negedge clock); #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=%b", grant, 4'b0000); end
        total++; if (ctrl_readReg !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=%0d", ctrl_readReg, 0); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=%b", rsp_valid, 4'b0000); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h exp=%h", rsp_data, 8'h00); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_hold_valid got=%b exp=%b", rsp_valid, 4'b0000); end
        @(negedge clock);
        reset = 1'b0; req = 4'b0000;
    endtask

    task automatic test_single();
        mem[3] = 8'h5A; mem[0] = 8'hA0;
        @(negedge clock);
        req = 4'b0001; req_addr = {3'd0, 3'd0, 3'd0, 3'd3}; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=%b", grant, 4'b0001); end
        total++; if (ctrl_readReg !== 3'd3) begin bad++; $display("FAIL single_addr got=%0d exp=%0d", ctrl_readReg, 3); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b exp=%b", rsp_valid, 4'b0001); end
        total++; if (rsp_data !== 8'h5A) begin bad++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, 8'h5A); end
        @(negedge clock);
        req = 4'b0011; req_addr = 12'h000; #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_ptr1_grant got=%b exp=%b", grant, 4'b0010); end
        total++; if (ctrl_readReg !== 3'd0) begin bad++; $display("FAIL single_ptr1_addr got=%0d exp=%0d", ctrl_readReg, 0); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL single_ptr1_valid got=%b exp=%b", rsp_valid, 4'b0010); end
        total++; if (rsp_data !== 8'hA0) begin bad++; $display("FAIL single_reg0_data got=%h exp=%h", rsp_data, 8'hA0); end
        @(negedge clock);
        req = 4'b0000; #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_grant got=%b exp=%b", grant, 4'b0000); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL idle_valid got=%b exp=%b", rsp_valid, 4'b0000); end
        total++; if (rsp_data !== 8'hA0) begin bad++; $display("FAIL idle_data_hold got=%h exp=%h", rsp_data, 8'hA0); end
    endtask

    task automatic test_wrap_and_freeze();
        mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
        @(negedge clock);
        req = 4'b0011; req_addr = {3'd0, 3'd7, 3'd6, 3'd5}; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_grant got=%b exp=%b", grant, 4'b0001); end
        total++; if (ctrl_readReg !== 3'd5) begin bad++; $display("FAIL wrap_addr got=%0d exp=%0d", ctrl_readReg, 5); end
        @(posedge clock); #1;
        total++; if (rsp_data !== 8'h55) begin bad++; $display("FAIL wrap_data got=%h exp=%h", rsp_data, 8'h55); end
        @(negedge clock); #1;
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL wrap_next_grant got=%b exp=%b", grant, 4'b0010); end
        total++; if (ctrl_readReg !== 3'd6) begin bad++; $display("FAIL wrap_next_addr got=%0d exp=%0d", ctrl_readReg, 6); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL wrap_next_valid got=%b exp=%b", rsp_valid, 4'b0010); end
        total++; if (rsp_data !== 8'h66) begin bad++; $display("FAIL wrap_next_data got=%h exp=%h", rsp_data, 8'h66); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            en = 1'b0; req = 4'b0110; #1;
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL freeze_grant cyc=%0d got=%b exp=%b", c, grant, 4'b0000); end
            total++; if (ctrl_readReg !== 3'd0) begin bad++; $display("FAIL freeze_addr cyc=%0d got=%0d exp=%0d", c, ctrl_readReg, 0); end
            @(posedge clock); #1;
            total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL freeze_valid cyc=%0d got=%b exp=%b", c, rsp_valid, 4'b0000); end
            total++; if (rsp_data !== 8'h66) begin bad++; $display("FAIL freeze_data cyc=%0d got=%h exp=%h", c, rsp_data, 8'h66); end
        end
        @(negedge clock);
        en = 1'b1; #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL unfreeze_grant got=%b exp=%b", grant, 4'b0100); end
        total++; if (ctrl_readReg !== 3'd7) begin bad++; $display("FAIL unfreeze_addr got=%0d exp=%0d", ctrl_readReg, 7); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL unfreeze_valid got=%b exp=%b", rsp_valid, 4'b0100); end
        total++; if (rsp_data !== 8'h77) begin bad++; $display("FAIL unfreeze_data got=%h exp=%h", rsp_data, 8'h77); end
        @(negedge clock);
        req = 4'b0000;
    endtask

    task automatic test_rotation();
        reset = 1'b1; #1;
        @(negedge clock);
        reset = 1'b0;
        mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
        req = 4'b1111; req_addr = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (grant !== rot_g[i]) begin bad++; $display("FAIL rot_grant step=%0d got=%b exp=%b", i, grant, rot_g[i]); end
            total++; if (ctrl_readReg !== rot_a[i]) begin bad++; $display("FAIL rot_addr step=%0d got=%0d exp=%0d", i, ctrl_readReg, rot_a[i]); end
            @(posedge clock); #1;
            total++; if (rsp_valid !== rot_g[i]) begin bad++; $display("FAIL rot_valid step=%0d got=%b exp=%b", i, rsp_valid, rot_g[i]); end
            total++; if (rsp_data !== rot_d[i]) begin bad++; $display("FAIL rot_data step=%0d got=%h exp=%h", i, rsp_data, rot_d[i]); end
            @(negedge clock);
        end
        req = 4'b0000;
    endtask

    task automatic test_drop();
        reset = 1'b1; #1;
        @(negedge clock);
        reset = 1'b0;
        req = 4'b0011; req_addr = {3'd0, 3'd0, 3'd2, 3'd1}; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL drop_first_grant got=%b exp=%b", grant, 4'b0001); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL drop_first_valid got=%b exp=%b", rsp_valid, 4'b0001); end
        @(negedge clock);
        req = 4'b0001; #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL drop_second_grant got=%b exp=%b", grant, 4'b0001); end
        total++; if (ctrl_readReg !== 3'd1) begin bad++; $display("FAIL drop_second_addr got=%0d exp=%0d", ctrl_readReg, 1); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL drop_second_valid got=%b exp=%b", rsp_valid, 4'b0001); end
        total++; if (rsp_data !== 8'h11) begin bad++; $display("FAIL drop_second_data got=%h exp=%h", rsp_data, 8'h11); end
        @(negedge clock);
        req = 4'b0000; #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_idle_grant got=%b exp=%b", grant, 4'b0000); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL drop_idle_valid got=%b exp=%b", rsp_valid, 4'b0000); end
    endtask

    task automatic test_reset_mid();
        mem[6] = 8'h66; mem[7] = 8'h77;
        @(negedge clock);
        req = 4'b0100; req_addr = {3'd7, 3'd6, 3'd0, 3'd0}; #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL mid_grant got=%b exp=%b", grant, 4'b0100); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL mid_valid got=%b exp=%b", rsp_valid, 4'b0100); end
        total++; if (rsp_data !== 8'h66) begin bad++; $display("FAIL mid_data got=%h exp=%h", rsp_data, 8'h66); end
        #2;
        reset = 1'b1; #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL async_rst_valid got=%b exp=%b", rsp_valid, 4'b0000); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL async_rst_data got=%h exp=%h", rsp_data, 8'h00); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL async_rst_grant got=%b exp=%b", grant, 4'b0000); end
        total++; if (ctrl_readReg !== 3'd0) begin bad++; $display("FAIL async_rst_addr got=%0d exp=%0d", ctrl_readReg, 0); end
        @(negedge clock);
        reset = 1'b0; req = 4'b1100; #1;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL post_rst_grant got=%b exp=%b", grant, 4'b0100); end
        total++; if (ctrl_readReg !== 3'd6) begin bad++; $display("FAIL post_rst_addr got=%0d exp=%0d", ctrl_readReg, 6); end
        @(posedge clock); #1;
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL post_rst_valid got=%b exp=%b", rsp_valid, 4'b0100); end
        total++; if (rsp_data !== 8'h66) begin bad++; $display("FAIL post_rst_data got=%h exp=%h", rsp_data, 8'h66); end
        @(negedge clock);
        req = 4'b0000;
    endtask

    initial begin
        for (int m = 0; m < 8; m++) mem[m] = 8'h00;
        test_reset();
        test_single();
        test_wrap_and_freeze();
        test_rotation();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog elapsed=%0t limit=%0d", $time, 50000);
        $fatal(1);
    end

endmodule
